serial_sub8: RTL and testbench

- Bit-serial, multi-cycle 8-bit subtractor; the inverse-direction companion to the team's parallel adder/accumulate datapath.
- Computes DIFF = A - B one bit per clock, LSB first, through a registered borrow flip-flop.
- Reports borrow-out, signed overflow and zero flags.
- Sits beside the adder in the ALU exercise datapath and uses a start/busy/done handshake, so a controller can sequence it.

---
 rtl/sub_pkg.sv | 18 +
 rtl/full_sub_bit.sv | 13 +
 rtl/serial_sub8.sv | 129 ++++++++++++
 tb/tb_serial_sub8.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/sub_pkg.sv
// Shared definitions for the bit-serial subtractor and its helper cells.
package sub_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_CNT_W = $clog2(DEFAULT_WIDTH + 1);

    // Counter must hold the value WIDTH itself, hence the +1.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/full_sub_bit.sv
// Combinational one-bit full subtractor: x - y - bin.
module full_sub_bit (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bo
);

    assign d  = x ^ y ^ bin;
    assign bo = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_sub8.sv
// Bit-serial A - B, LSB first, with a registered borrow and a start/busy/done handshake.
module serial_sub8
    import sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf,
    output logic             zero
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic             borrow_q, borrow_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic             sa_msb_q, sa_msb_d;
    logic             sb_msb_q, sb_msb_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;

    logic             bit_d;
    logic             bit_bo;

    full_sub_bit u_bit (
        .x   (sa_q[0]),
        .y   (sb_q[0]),
        .bin (borrow_q),
        .d   (bit_d),
        .bo  (bit_bo)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            count_q  <= '0;
            borrow_q <= 1'b0;
            sa_q     <= '0;
            sb_q     <= '0;
            sa_msb_q <= 1'b0;
            sb_msb_q <= 1'b0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            borrow_q <= borrow_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            sa_msb_q <= sa_msb_d;
            sb_msb_q <= sb_msb_d;
            diff_q   <= diff_d;
            bout_q   <= bout_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        borrow_d = borrow_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        sa_msb_d = sa_msb_q;
        sb_msb_d = sb_msb_q;
        diff_d   = diff_q;
        bout_d   = bout_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    sa_d     = a;
                    sb_d     = b;
                    sa_msb_d = a[WIDTH-1];
                    sb_msb_d = b[WIDTH-1];
                    borrow_d = 1'b0;
                    count_d  = '0;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                diff_d   = {bit_d, diff_q[WIDTH-1:1]};
                sa_d     = sa_q >> 1;
                sb_d     = sb_q >> 1;
                borrow_d = bit_bo;
                count_d  = count_q + 1'b1;
                // Flags are only refreshed on the final bit, so they hold the
                // previous result while the new difference is shifting in.
                if (count_q == CW'(WIDTH - 1)) begin
                    state_d = DONE;
                    bout_d  = bit_bo;
                    ovf_d   = (sa_msb_q != sb_msb_q) && (bit_d != sa_msb_q);
                    zero_d  = (diff_d == '0);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy = (state_q == SHIFT);
    assign done = (state_q == DONE);
    assign diff = diff_q;
    assign bout = bout_q;
    assign ovf  = ovf_q;
    assign zero = zero_q;

endmodule

// File: tb/tb_serial_sub8.sv
// Directed plus randomized bench for serial_sub8 against an arithmetic reference model.
module tb_serial_sub8;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;
    logic         zero;

    int n_vec = 0;
    int n_err = 0;

    logic [W-1:0] prev_diff;
    logic         prev_bout;
    logic         prev_ovf;
    logic         prev_zero;

    serial_sub8 #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout),
        .ovf   (ovf),
        .zero  (zero)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_diff"}, 32'(diff), 32'd0);
        chk({tag, "_bout"}, 32'(bout), 32'd0);
        chk({tag, "_ovf"},  32'(ovf),  32'd0);
        chk({tag, "_zero"}, 32'(zero), 32'd0);
    endtask

    // Reference: plain unsigned/signed arithmetic on the operands.
    task automatic model(input logic [W-1:0] ta, input logic [W-1:0] tbv,
                         output logic [W-1:0] ed, output logic eb,
                         output logic eo, output logic ez);
        int ud;
        int sd;
        ud = int'(ta) - int'(tbv);
        sd = int'($signed(ta)) - int'($signed(tbv));
        ed = W'((ud + 256) % 256);
        eb = (ud < 0);
        eo = (sd > 127) || (sd < -128);
        ez = (ed == 0);
    endtask

    // One operation: start at a negedge, checked every cycle until back in IDLE.
    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tbv,
                         input bit pulse, input string tag);
        logic [W-1:0] ed;
        logic         eb, eo, ez;
        model(ta, tbv, ed, eb, eo, ez);
        @(negedge clk);
        start = 1'b1;
        a     = ta;
        b     = tbv;
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            chk({tag, "_busy"}, 32'(busy), 32'd1);
            chk({tag, "_nodone"}, 32'(done), 32'd0);
            chk({tag, "_holdflags"}, {29'd0, bout, ovf, zero},
                {29'd0, prev_bout, prev_ovf, prev_zero});
            if (i == 0) begin
                start = 1'b0;
                a     = W'($urandom);
                b     = W'($urandom);
            end
            if (pulse && i == 3) begin
                start = 1'b1;
                a     = 8'h11;
            end
            if (pulse && i == 4) start = 1'b0;
        end
        @(negedge clk);
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_busy_off"}, 32'(busy), 32'd0);
        chk({tag, "_diff"}, 32'(diff), 32'(ed));
        chk({tag, "_bout"}, 32'(bout), 32'(eb));
        chk({tag, "_ovf"},  32'(ovf),  32'(eo));
        chk({tag, "_zero"}, 32'(zero), 32'(ez));
        $display("op %s: a=%02h b=%02h -> diff=%02h bout=%0d ovf=%0d zero=%0d", tag, ta, tbv, diff, bout, ovf, zero);
        prev_diff = ed;
        prev_bout = eb;
        prev_ovf  = eo;
        prev_zero = ez;
        @(negedge clk);
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
        chk({tag, "_idle"}, 32'(busy), 32'd0);
        chk({tag, "_diff_hold"}, 32'(diff), 32'(ed));
        @(negedge clk);
        chk({tag, "_no_extra_op"}, {30'd0, busy, done}, 32'd0);
    endtask

    initial begin
        int           done_at[$];
        int           cyc;
        logic [W-1:0] ed;
        logic         eb, eo, ez;

        rst   = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        prev_diff = '0;
        prev_bout = 1'b0;
        prev_ovf  = 1'b0;
        prev_zero = 1'b0;

        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;

        // Reset mid-SHIFT: outputs clear asynchronously and no done follows.
        @(negedge clk);
        start = 1'b1;
        a     = 8'h05;
        b     = 8'h0A;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("midrst_busy_before", 32'(busy), 32'd1);
        #2 rst = 1'b1;
        #1 chk_all_zero("midrst");
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            n_vec++;
            assert (done === 1'b0 && busy === 1'b0) else begin
                n_err++;
                $error("FAIL midrst_nodone: observed busy=%0b done=%0b expected 0 0", busy, done);
            end
        end
        do_op(8'h05, 8'h0A, 1'b0, "after_rst");

        do_op(8'h01, 8'h06, 1'b0, "borrow");
        do_op(8'h64, 8'h64, 1'b0, "equal");
        do_op(8'h7F, 8'h01, 1'b0, "nonzero");
        do_op(8'h80, 8'h01, 1'b0, "ovf_neg");
        do_op(8'h7F, 8'hFF, 1'b0, "ovf_pos");
        do_op(8'h00, 8'h01, 1'b0, "wrap");
        do_op(8'h30, 8'h10, 1'b1, "ignored_start");

        // Start held high: three back-to-back operations, operands scrambled mid-flight.
        model(8'h64, 8'h7F, ed, eb, eo, ez);
        @(negedge clk);
        start = 1'b1;
        a     = 8'h64;
        b     = 8'h7F;
        cyc   = 0;
        while (done_at.size() < 3 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (done) begin
                done_at.push_back(cyc);
                chk("held_diff", 32'(diff), 32'(ed));
                chk("held_bout", 32'(bout), 32'(eb));
                $display("held op %0d at cycle %0d: diff=%02h bout=%0d", done_at.size(), cyc, diff, bout);
                a = 8'h64;
                b = 8'h7F;
                if (done_at.size() == 3) start = 1'b0;
            end else if (busy) begin
                a = W'($urandom);
                b = W'($urandom);
            end else begin
                a = 8'h64;
                b = 8'h7F;
            end
        end
        chk("held_count", 32'(done_at.size()), 32'd3);
        if (done_at.size() == 3) begin
            chk("held_gap1", 32'(done_at[1] - done_at[0]), 32'd10);
            chk("held_gap2", 32'(done_at[2] - done_at[1]), 32'd10);
        end
        prev_diff = ed;
        prev_bout = eb;
        prev_ovf  = eo;
        prev_zero = ez;
        repeat (2) @(negedge clk);
        chk("held_released", {30'd0, busy, done}, 32'd0);

        for (int n = 0; n < 25; n++) begin
            do_op(W'($urandom), W'($urandom), 1'b0, $sformatf("rand%0d", n));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
